muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS CPU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, one shift-add or shift-subtract step per cycle.
- Drives busy so the CPU control unit stalls MFHI, MFLO and any new mul/div until the result is ready.
- Sits beside the ALU, fed from the register file read ports; the main control unit issues start along with Funct[1:0].

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per operation (equals WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- start  in  1  launch an operation; sampled in IDLE only.
- op  in  2  Funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; op[0]=0 means signed.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- mthi  in  1  write a into HI.
- mtlo  in  1  write a into LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.

Behaviour:
- Reset (reset=0 at an edge), including mid-operation:
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Iteration counter and working registers cleared.
  - Any in-flight result is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op, sign flags, |a| and |b| (absolute values when signed, raw otherwise), count=0; go to CALC. busy=1 from E0.
  - Else, mthi/mtlo write a into hi/lo at the edge. Both may be asserted together.
  - start has priority over mthi/mtlo in the same cycle; the writes are then dropped.
- CALC:
  - One iteration per edge, E1..E32. count increments; on count=ITER-1 go to FIX.
  - Multiply: unsigned shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract; partial remainder WIDTH+1 bits.
- FIX (edge E33):
  - Apply signs. Signed multiply: product negated if sign(a)≠sign(b). Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Multiply writes hi=product[63:32], lo=product[31:0]. Divide writes lo=quotient, hi=remainder.
  - Go to IDLE; busy=0 and done=1 in the cycle after E33.
  - Fixed latency: result visible 34 edges after the start edge, independent of operand values.
- Divide by zero: same latency; lo=32'hFFFFFFFF, hi=a (original, unmodified dividend), for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Result wraps; no trap.
- While busy:
  - start, mthi and mtlo are ignored. The CPU must stall; the unit does not queue requests.
  - hi/lo hold their previous values until the FIX edge.
- done is high for exactly one cycle. start may be accepted in that same cycle (state is IDLE), back-to-back.
- Operand inputs are not required to be stable after E0.

Decomposition:
- Shared package/header:
  - op encodings (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11).
  - State encodings (IDLE, CALC, FIX).
  - WIDTH default.
- Sub-module md_iter_step: combinational single iteration (add-shift or subtract-shift, selected by mode). The sequencer owns the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → busy for 34 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIV a=0xFFFFFFF9 (-7), b=2, started in the done cycle → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064, after 34 edges. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi a=0x12345678 in IDLE → hi=0x12345678 next edge. Then start MULTU 2×3 with mtlo=1 in the same cycle → mtlo dropped; final hi=0, lo=6.
- During CALC, pulse start, mthi and mtlo with a=0xDEADBEEF → no effect on hi/lo, latency or result.
- Start DIVU 50/7, drive reset=0 at edge E10 → next cycle busy=0, done=0, hi=lo=0. A new start completes normally with lo=7, hi=1.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_sequencer_pkg;

  localparam int unsigned MdWidth = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } md_state_e;

endpackage

// File: rtl/md_iter_step.sv
// One unsigned iteration: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum     = {1'b0, rem_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {rem_i, lo_i[WIDTH-1]};
    // A successful subtract always leaves a value below the divisor, so W bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    fits    = shifted >= {1'b0, opnd_i};
    if (div_i) begin
      rem_o = fits ? diff : shifted[WIDTH-1:0];
      lo_o  = {lo_i[WIDTH-2:0], fits};
    end else begin
      rem_o = sum[WIDTH:1];
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO multiply/divide sequencer: fixed-latency iterative MULT/MULTU/DIV/DIVU.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MdWidth,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CntW    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_a_q, neg_a_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               op_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] prod;

  md_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_i  (is_div_q),
    .rem_i  (work_hi_q),
    .lo_i   (work_lo_q),
    .opnd_i (opnd_q),
    .rem_o  (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_a_d    = neg_a_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    op_signed = (op == MD_MULT) || (op == MD_DIV);
    sign_a    = op_signed & a[WIDTH-1];
    sign_b    = op_signed & b[WIDTH-1];

    prod = {work_hi_q, work_lo_q};
    if (neg_res_q) prod = -prod;
    quot = neg_res_q ? -work_lo_q : work_lo_q;
    rem  = neg_a_q ? -work_hi_q : work_hi_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCalc;
          count_d    = '0;
          work_hi_d  = '0;
          work_lo_d  = sign_a ? -a : a;
          opnd_d     = sign_b ? -b : b;
          is_div_d   = (op == MD_DIV) || (op == MD_DIVU);
          neg_res_d  = sign_a ^ sign_b;
          neg_a_d    = sign_a;
          div_zero_d = (b == '0);
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      StCalc: begin
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        count_d   = count_q + 1'b1;
        if (count_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        // With a zero divisor every step "fits", so the remainder ends up as |a|
        // and the dividend sign restores the original a.
        if (is_div_q) begin
          lo_d = div_zero_q ? '1 : quot;
          hi_d = rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_a_q    <= neg_a_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus scoreboard of HI/LO results.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  muldiv_sequencer #(
    .WIDTH (32),
    .ITER  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          noise;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  logic prev_done = 1'b0;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Scoreboard: every done pulse retires the oldest outstanding operation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
      end
      chk("done_width", 64'(prev_done), 64'd0);
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the negedge where done is first seen.
  task automatic run_op(input vec_t v);
    logic [31:0] hold_hi, hold_lo;
    int          n;
    bit          held;
    hold_hi = hi;
    hold_lo = lo;
    held    = 1'b1;
    start   = 1'b1;
    op      = v.op;
    a       = v.a;
    b       = v.b;
    sb_q.push_back('{hi: v.hi, lo: v.lo, name: v.name});
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n     = 1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1 || hi !== hold_hi || lo !== hold_lo) held = 1'b0;
      if (v.noise && n == 5) begin
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        a     = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    // Edges counted from the start edge inclusive through the FIX edge.
    chk({v.name, "_latency"}, 64'(n), 64'd34);
    chk({v.name, "_busy_hold"}, 64'(held), 64'd1);
    chk({v.name, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = MD_MULT;
    a     = '0;
    b     = '0;

    vt[0]  = '{op: MD_MULT,  a: 32'hFFFFFFFD, b: 32'd7,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB,
               noise: 1'b1, name: "mult_m3x7"};
    vt[1]  = '{op: MD_MULTU, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001,
               noise: 1'b0, name: "multu_max"};
    vt[2]  = '{op: MD_DIV,   a: 32'hFFFFFFF9, b: 32'd2,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD,
               noise: 1'b0, name: "div_m7by2"};
    vt[3]  = '{op: MD_DIVU,  a: 32'd100,      b: 32'd0,        hi: 32'h00000064, lo: 32'hFFFFFFFF,
               noise: 1'b0, name: "divu_by0"};
    vt[4]  = '{op: MD_DIV,   a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000,
               noise: 1'b0, name: "div_ovf"};
    vt[5]  = '{op: MD_DIV,   a: 32'hFFFFFFF9, b: 32'd0,        hi: 32'hFFFFFFF9, lo: 32'hFFFFFFFF,
               noise: 1'b0, name: "div_neg_by0"};
    vt[6]  = '{op: MD_MULT,  a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000,
               noise: 1'b0, name: "mult_minsq"};
    vt[7]  = '{op: MD_DIV,   a: 32'd7,        b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD,
               noise: 1'b1, name: "div_7bym2"};
    vt[8]  = '{op: MD_DIVU,  a: 32'hFFFFFFFF, b: 32'd16,       hi: 32'h0000000F, lo: 32'h0FFFFFFF,
               noise: 1'b0, name: "divu_max16"};
    vt[9]  = '{op: MD_MULT,  a: 32'd5,        b: 32'hFFFFFFFC, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEC,
               noise: 1'b0, name: "mult_5xm4"};
    vt[10] = '{op: MD_MULTU, a: 32'd0,        b: 32'hCAFEF00D, hi: 32'h00000000, lo: 32'h00000000,
               noise: 1'b0, name: "multu_zero"};
    vt[11] = '{op: MD_DIVU,  a: 32'h80000000, b: 32'd3,        hi: 32'h00000002, lo: 32'h2AAAAAAA,
               noise: 1'b0, name: "divu_big3"};

    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: each operation starts in the previous one's done cycle.
    for (int i = 0; i < 12; i++) run_op(vt[i]);

    @(negedge clk);
    mthi = 1'b1;
    a    = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_lo_keep", 64'(lo), 64'(vt[11].lo));

    mtlo = 1'b1;
    v = '{op: MD_MULTU, a: 32'd2, b: 32'd3, hi: 32'h0, lo: 32'd6, noise: 1'b0, name: "multu_mtlo_drop"};
    run_op(v);

    @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    a    = 32'hA5A55A5A;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'hA5A55A5A);
    chk("mthilo_lo", 64'(lo), 64'hA5A55A5A);

    // Reset lands on edge E10 of a DIVU.
    start = 1'b1;
    op    = MD_DIVU;
    a     = 32'd50;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    v = '{op: MD_DIVU, a: 32'd50, b: 32'd7, hi: 32'd1, lo: 32'd7, noise: 1'b0, name: "divu_50by7"};
    run_op(v);

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
